bambu_minimal_mem_initiator: RTL and testbench

- Synthesizable initiator for the Bambu minimal memory interface, single channel.
- Accepts burst commands (read or write, start address, beat count, access size) on a valid/ready port and drives oe/we/addr/Wdata/size toward a minimal-interface responder (an accelerator slave port or an off-chip memory model).
- For every beat it waits for DataRdy and returns read data on a response stream.
- Used to preload accelerator memories and read results back without the simulation testbench.

---
 rtl/bambu_minimal_mem_initiator.sv | 234 +++++++++++++++++++++++
 tb/tb_bambu_minimal_mem_initiator.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bambu_minimal_mem_initiator.sv
// bambu_minimal_mem_initiator
//
// Single-channel initiator for the Bambu minimal memory interface. It takes
// burst commands (read/write, start address, beat count, access size) from a
// host, runs one access per beat towards a minimal-interface responder and
// returns read beats on a valid/ready stream. Its job is to preload
// accelerator memories and read results back without a simulation testbench.
//
// Optional feature: define MEM_INIT_TIMEOUT_EN to abort an access that gets
// no M_DataRdy within TIMEOUT_CYC cycles. The block then parks in an error
// state with a sticky err flag until reset. Without the macro err is tied low
// and an access waits forever.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   cmd_*                   burst command (valid/ready)
//   wr_valid/ready/data     host write beats, one per write-burst beat
//   rd_valid/ready/data     read beats back to the host; rd_last on final beat
//   busy, done, err         burst in progress, one-cycle end pulse, timeout
//   Mout_*                  strobes, address, write data and size to responder
//   M_Rdata_ram, M_DataRdy  responder read data and access-complete
//
// Every output is a register, so reset forces all of them low at once.
module bambu_minimal_mem_initiator #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SIZE_W      = 4,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [SIZE_W-1:0] cmd_size,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_ACCESS,
        S_RESP,
        S_GAP
`ifdef MEM_INIT_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              write_reg;

    // Sizes of 0 or wider than the data bus mean "whole bus".
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
        if (s == '0 || 32'(s) > DATA_W) begin
            return SIZE_W'(DATA_W);
        end
        return s;
    endfunction

    // Low-size-bits mask applied to captured read data. The size register
    // always holds a clamped value, so the mask never exceeds the bus.
    logic [DATA_W-1:0] size_mask;
    genvar gi;
    for (gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign size_mask[gi] = (32'(Mout_data_ram_size) > gi);
    end

    // Address step is the access width in bytes, but at least one so that
    // sub-byte accesses still walk through memory.
    logic [SIZE_W-1:0] size_bytes;
    logic [ADDR_W-1:0] addr_step;
    assign size_bytes = Mout_data_ram_size >> 3;
    assign addr_step  = (size_bytes == '0) ? ADDR_W'(1) : ADDR_W'(size_bytes);

`ifdef MEM_INIT_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_W-1:0] tcnt_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            len_reg            <= '0;
            write_reg          <= 1'b0;
            cmd_ready          <= 1'b0;
            wr_ready           <= 1'b0;
            rd_valid           <= 1'b0;
            rd_data            <= '0;
            rd_last            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            Mout_oe_ram        <= 1'b0;
            Mout_we_ram        <= 1'b0;
            Mout_addr_ram      <= '0;
            Mout_Wdata_ram     <= '0;
            Mout_data_ram_size <= '0;
`ifdef MEM_INIT_TIMEOUT_EN
            tcnt_reg           <= '0;
            err                <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
            // The wait counter only runs in ACCESS, so every beat starts at 0.
            if (state_reg != S_ACCESS) begin
                tcnt_reg <= '0;
            end
`endif
            case (state_reg)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        Mout_addr_ram      <= cmd_addr;
                        Mout_data_ram_size <= clamp_size(cmd_size);
                        len_reg            <= cmd_len;
                        write_reg          <= cmd_write;
                        if (cmd_len == '0) begin
                            // Empty burst: acknowledge only, no bus activity.
                            done <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (cmd_write) begin
                                wr_ready  <= 1'b1;
                                state_reg <= S_WDATA;
                            end else begin
                                Mout_oe_ram <= 1'b1;
                                state_reg   <= S_ACCESS;
                            end
                        end
                    end
                end

                S_WDATA: begin
                    if (wr_valid && wr_ready) begin
                        Mout_Wdata_ram <= wr_data;
                        wr_ready       <= 1'b0;
                        Mout_we_ram    <= 1'b1;
                        state_reg      <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (M_DataRdy) begin
                        Mout_oe_ram <= 1'b0;
                        Mout_we_ram <= 1'b0;
                        if (write_reg) begin
                            state_reg <= S_GAP;
                        end else begin
                            rd_data   <= M_Rdata_ram & size_mask;
                            rd_valid  <= 1'b1;
                            rd_last   <= (len_reg == LEN_W'(1));
                            state_reg <= S_RESP;
                        end
                    end
`ifdef MEM_INIT_TIMEOUT_EN
                    else if (tcnt_reg == TCNT_W'(TIMEOUT_CYC - 1)) begin
                        Mout_oe_ram <= 1'b0;
                        Mout_we_ram <= 1'b0;
                        err         <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_reg   <= S_ERR;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        state_reg <= S_GAP;
                    end
                end

                S_GAP: begin
                    // Strobes are already low here; this cycle separates beats.
                    len_reg       <= len_reg - 1'b1;
                    Mout_addr_ram <= Mout_addr_ram + addr_step;
                    if (len_reg != LEN_W'(1)) begin
                        if (write_reg) begin
                            wr_ready  <= 1'b1;
                            state_reg <= S_WDATA;
                        end else begin
                            Mout_oe_ram <= 1'b1;
                            state_reg   <= S_ACCESS;
                        end
                    end else begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end

`ifdef MEM_INIT_TIMEOUT_EN
                S_ERR: begin
                    // Parked until reset; cmd_ready stays low.
                    cmd_ready <= 1'b0;
                end
`endif

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bambu_minimal_mem_initiator.sv
// Testbench for bambu_minimal_mem_initiator: a responder model with
// adjustable latency, a reference memory and burst rules computed directly
// from addresses/sizes, and one task per scenario.
module tb_bambu_minimal_mem_initiator;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [SW-1:0] cmd_size = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic          err;
    logic          Mout_oe_ram;
    logic          Mout_we_ram;
    logic [AW-1:0] Mout_addr_ram;
    logic [DW-1:0] Mout_Wdata_ram;
    logic [SW-1:0] Mout_data_ram_size;
    logic [DW-1:0] M_Rdata_ram;
    logic          M_DataRdy;

    always #5 clock = ~clock;

    bambu_minimal_mem_initiator #(
        .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .LEN_W(LW), .TIMEOUT_CYC(16)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .err(err),
        .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
        .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
        .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy)
    );

    int passed = 0;
    int total = 0;
    int expired = 0;
    int stab_bad = 0;

    // ---------------- responder model ----------------
    int         lat = 1;          // cycles an access stays open; 0 = never answers
    int         wait_cnt = 0;
    logic [7:0] mem [128];
    bit         mem_ready = 1'b0;
    logic       acc_we [$];
    logic [6:0] acc_addr [$];
    logic [3:0] acc_size [$];
    logic [7:0] acc_data [$];

    function automatic logic [7:0] resp_mask(input logic [3:0] s);
        if (s == 4'd0 || s >= 4'd8) return 8'hFF;
        return 8'((1 << s) - 1);
    endfunction

    assign M_DataRdy   = (Mout_oe_ram || Mout_we_ram) && (lat != 0) && (wait_cnt == lat - 1);
    assign M_Rdata_ram = mem[Mout_addr_ram];

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'(i + 16);
            mem_ready = 1'b1;
        end
        if (M_DataRdy) begin
            acc_we.push_back(Mout_we_ram);
            acc_addr.push_back(Mout_addr_ram);
            acc_size.push_back(Mout_data_ram_size);
            acc_data.push_back(Mout_we_ram ? Mout_Wdata_ram : M_Rdata_ram);
            if (Mout_we_ram) mem[Mout_addr_ram] = Mout_Wdata_ram & resp_mask(Mout_data_ram_size);
        end
        if ((Mout_oe_ram || Mout_we_ram) && !M_DataRdy) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // ---------------- bus monitor ----------------
    int   oe_starts = 0, we_starts = 0, we_cycles = 0, done_cnt = 0, both_cnt = 0;
    logic oe_prev = 1'b0, we_prev = 1'b0;

    always @(negedge clock) begin
        if (Mout_oe_ram && Mout_we_ram) both_cnt++;
        if (Mout_oe_ram && !oe_prev) oe_starts++;
        if (Mout_we_ram && !we_prev) we_starts++;
        if (Mout_we_ram) we_cycles++;
        if (done) done_cnt++;
        oe_prev = Mout_oe_ram;
        we_prev = Mout_we_ram;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [128];
    logic [7:0] wq [$];
    logic [7:0] rd_q [$];
    logic       last_q [$];

    function automatic int eff_size(input int s);
        return (s == 0 || s > 8) ? 8 : s;
    endfunction
    function automatic logic [7:0] model_mask(input int s);
        return 8'((1 << eff_size(s)) - 1);
    endfunction
    function automatic int model_step(input int s);
        return (eff_size(s) / 8 < 1) ? 1 : eff_size(s) / 8;
    endfunction

    // ---------------- host driver ----------------
    task automatic drive_burst(input bit wr, input int a, input int n, input int sz, input int hold);
        int k;
        logic [7:0] d0;
        $display("burst %s addr=0x%02h len=%0d size=%0d hold=%0d lat=%0d",
                 wr ? "write" : "read", a, n, sz, hold, lat);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 200) begin @(negedge clock); k++; end
        if (k >= 200) begin expired++; return; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 7'(a); cmd_len = 8'(n); cmd_size = 4'(sz);
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (wr) begin
                k = 0;
                while (wr_ready !== 1'b1 && k < 200) begin @(negedge clock); k++; end
                if (k >= 200) begin expired++; return; end
                repeat (hold) @(negedge clock);
                wr_valid = 1'b1; wr_data = wq[b];
                @(negedge clock);
                wr_valid = 1'b0;
            end else begin
                k = 0;
                while (rd_valid !== 1'b1 && k < 200) begin @(negedge clock); k++; end
                if (k >= 200) begin expired++; return; end
                d0 = rd_data;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clock);
                    if (rd_valid !== 1'b1 || rd_data !== d0 || Mout_oe_ram !== 1'b0) stab_bad++;
                end
                rd_q.push_back(rd_data);
                last_q.push_back(rd_last);
                rd_ready = 1'b1;
                @(negedge clock);
                rd_ready = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin @(negedge clock); k++; end
        if (k >= 300) expired++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++;
        if ({cmd_ready, wr_ready, rd_valid, rd_last, busy, done, err, Mout_oe_ram, Mout_we_ram} !== 9'b0)
            $display("FAIL reset_ctrl got=%b want=0", {cmd_ready, wr_ready, rd_valid, rd_last, busy, done, err, Mout_oe_ram, Mout_we_ram});
        else passed++;
        total++;
        if ({Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, rd_data} !== 27'b0)
            $display("FAIL reset_data got=%h want=0", {Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, rd_data});
        else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({cmd_ready, busy} !== 2'b10) $display("FAIL idle_after_reset got=%b want=10", {cmd_ready, busy});
        else passed++;
    endtask

    task automatic test_read_basic();
        int base = acc_addr.size();
        int s_oe = oe_starts;
        logic [7:0] got;
        logic       gl;
        lat = 2;
        rd_q.delete(); last_q.delete();
        drive_burst(1'b0, 5, 3, 8, 0);
        total++;
        if (done !== 1'b0) $display("FAIL read_done_early got=%b want=0", done); else passed++;
        @(negedge clock);
        total++;
        if ({done, busy} !== 2'b10) $display("FAIL read_done_pulse got=%b want=10", {done, busy}); else passed++;
        @(negedge clock);
        total++;
        if (done !== 1'b0) $display("FAIL read_done_once got=%b want=0", done); else passed++;
        for (int b = 0; b < 3; b++) begin
            got = (b < rd_q.size()) ? rd_q[b] : 8'hxx;
            gl  = (b < last_q.size()) ? last_q[b] : 1'bx;
            total++;
            if (got !== (ref_mem[5 + b] & model_mask(8)))
                $display("FAIL read_data beat=%0d got=%h want=%h", b, got, ref_mem[5 + b]);
            else passed++;
            total++;
            if (gl !== (b == 2)) $display("FAIL read_last beat=%0d got=%b want=%b", b, gl, (b == 2));
            else passed++;
        end
        total++;
        if (oe_starts - s_oe !== 3) $display("FAIL read_strobes got=%0d want=3", oe_starts - s_oe);
        else passed++;
        total++;
        if (acc_addr.size() < base + 3 || acc_addr[base + 2] !== 7'h07)
            $display("FAIL read_addr got=%0d accesses want=3 ending at 07", acc_addr.size() - base);
        else passed++;
    endtask

    task automatic test_write_wrap();
        int base = acc_addr.size();
        int s_we = we_cycles;
        int d0 = done_cnt;
        int bad = 0;
        logic [6:0] ea;
        lat = 1;
        wq.delete(); wq.push_back(8'hA1); wq.push_back(8'hA2); wq.push_back(8'hA3);
        drive_burst(1'b1, 7'h7E, 3, 8, 0);
        wait_done(d0);
        for (int b = 0; b < 3; b++) begin
            ea = 7'((8'h7E + b) % 128);
            ref_mem[ea] = wq[b];
            if (acc_addr.size() <= base + b) bad++;
            else if (acc_addr[base + b] !== ea || acc_we[base + b] !== 1'b1 || acc_data[base + b] !== wq[b]) bad++;
            total++;
            if (mem[ea] !== wq[b]) $display("FAIL write_mem addr=%h got=%h want=%h", ea, mem[ea], wq[b]);
            else passed++;
        end
        total++;
        if (bad !== 0) $display("FAIL write_accesses bad=%0d want=0", bad); else passed++;
        total++;
        if (we_cycles - s_we !== 3) $display("FAIL write_we_cycles got=%0d want=3", we_cycles - s_we);
        else passed++;
    endtask

    task automatic test_len_zero();
        int s_st = oe_starts + we_starts;
        int k = 0;
        $display("burst write addr=0x11 len=0");
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        if (k >= 50) expired++;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h11; cmd_len = 8'd0; cmd_size = 4'd8;
        @(negedge clock);
        cmd_valid = 1'b0;
        total++;
        if ({done, cmd_ready, busy} !== 3'b110) $display("FAIL len0_pulse got=%b want=110", {done, cmd_ready, busy});
        else passed++;
        @(negedge clock);
        total++;
        if ({done, cmd_ready} !== 2'b01) $display("FAIL len0_after got=%b want=01", {done, cmd_ready});
        else passed++;
        repeat (3) @(negedge clock);
        total++;
        if (oe_starts + we_starts - s_st !== 0) $display("FAIL len0_strobes got=%0d want=0", oe_starts + we_starts - s_st);
        else passed++;
    endtask

    task automatic test_backpressure();
        int base = acc_addr.size();
        int s_sb = stab_bad;
        int d0 = done_cnt;
        int bad = 0;
        lat = 1;
        rd_q.delete(); last_q.delete();
        drive_burst(1'b0, 7'h20, 2, 8, 5);
        wait_done(d0);
        total++;
        if (stab_bad - s_sb !== 0) $display("FAIL hold_stable violations=%0d want=0", stab_bad - s_sb);
        else passed++;
        for (int b = 0; b < 2; b++) begin
            if (acc_addr.size() <= base + b || acc_addr[base + b] !== 7'(32 + b)) bad++;
            if (rd_q.size() <= b || rd_q[b] !== ref_mem[32 + b]) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL hold_beats bad=%0d want=0", bad); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        int base;
        int d0;
        int bad = 0;
        lat = 50;
        $display("burst read addr=0x40 len=2 (reset mid-burst)");
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h40; cmd_len = 8'd2; cmd_size = 4'd8;
        @(negedge clock);
        cmd_valid = 1'b0;
        k = 0;
        while (Mout_oe_ram !== 1'b1 && k < 20) begin @(negedge clock); k++; end
        if (k >= 20) expired++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if ({Mout_oe_ram, busy, rd_valid} !== 3'b000) $display("FAIL reset_mid got=%b want=000", {Mout_oe_ram, busy, rd_valid});
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        lat = 1;
        base = acc_addr.size();
        d0 = done_cnt;
        rd_q.delete(); last_q.delete();
        drive_burst(1'b0, 7'h10, 2, 4, 1);
        wait_done(d0);
        for (int b = 0; b < 2; b++) begin
            if (acc_addr.size() <= base + b || acc_addr[base + b] !== 7'(16 + b)) bad++;
            if (rd_q.size() <= b || rd_q[b] !== (ref_mem[16 + b] & 8'h0F)) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL after_reset_burst bad=%0d want=0", bad); else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            bit wr = 1'($urandom_range(0, 1));
            int a = $urandom_range(0, 127);
            int n = $urandom_range(1, 5);
            int sz = $urandom_range(0, 15);
            int hold = $urandom_range(0, 2);
            int base = acc_addr.size();
            int d0 = done_cnt;
            int bad = 0;
            logic [6:0] ea;
            lat = $urandom_range(1, 3);
            wq.delete(); rd_q.delete(); last_q.delete();
            if (wr) for (int b = 0; b < n; b++) wq.push_back(8'($urandom));
            drive_burst(wr, a, n, sz, hold);
            wait_done(d0);
            if (acc_addr.size() - base !== n) bad++;
            for (int b = 0; b < n; b++) begin
                ea = 7'((a + b * model_step(sz)) % 128);
                if (acc_addr.size() <= base + b) bad++;
                else if (acc_addr[base + b] !== ea || acc_size[base + b] !== 4'(eff_size(sz)) ||
                         acc_we[base + b] !== wr) bad++;
                if (wr) begin
                    if (acc_data.size() <= base + b || acc_data[base + b] !== wq[b]) bad++;
                    ref_mem[ea] = wq[b] & model_mask(sz);
                end else begin
                    if (rd_q.size() <= b || rd_q[b] !== (ref_mem[ea] & model_mask(sz))) bad++;
                    if (last_q.size() <= b || last_q[b] !== (b == n - 1)) bad++;
                end
            end
            total++;
            if (bad !== 0) $display("FAIL random_burst it=%0d bad=%0d want=0", it, bad); else passed++;
        end
    endtask

`ifdef MEM_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        int cnt = 0;
        int d0 = done_cnt;
        logic seen_ready = 1'b0;
        lat = 0;
        $display("burst read addr=0x03 len=1 (no responder)");
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h03; cmd_len = 8'd1; cmd_size = 4'd8;
        @(negedge clock);
        cmd_valid = 1'b0;
        k = 0;
        while (Mout_oe_ram !== 1'b1 && k < 20) begin @(negedge clock); k++; end
        while (Mout_oe_ram === 1'b1 && cnt < 100) begin cnt++; @(negedge clock); end
        total++;
        if (cnt !== 16) $display("FAIL timeout_cycles got=%0d want=16", cnt); else passed++;
        total++;
        if ({err, done} !== 2'b11) $display("FAIL timeout_flags got=%b want=11", {err, done}); else passed++;
        repeat (5) begin @(negedge clock); seen_ready |= cmd_ready; end
        total++;
        if ({seen_ready, err, done_cnt - d0 == 1} !== 3'b011)
            $display("FAIL timeout_park got=%b want=011", {seen_ready, err, done_cnt - d0 == 1});
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        lat = 1;
        repeat (2) @(negedge clock);
        total++;
        if ({err, cmd_ready} !== 2'b01) $display("FAIL timeout_cleared got=%b want=01", {err, cmd_ready});
        else passed++;
    endtask
`endif

    task automatic test_final();
        int bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        total++;
        if (bad !== 0) $display("FAIL final_mem differing=%0d want=0", bad); else passed++;
        total++;
        if (both_cnt !== 0) $display("FAIL oe_we_overlap got=%0d want=0", both_cnt); else passed++;
        total++;
        if (expired !== 0) $display("FAIL wait_bounds expired=%0d want=0", expired); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i + 16);
        test_reset();
        test_read_basic();
        test_write_wrap();
        test_len_zero();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
`ifdef MEM_INIT_TIMEOUT_EN
        test_timeout();
`endif
        test_final();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
